freq_ascii_uart_tx: RTL and testbench



---
 rtl/freq_ascii_uart_tx.sv | 155 +++++++++++++++
 tb/tb_freq_ascii_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_ascii_uart_tx.sv
// 8N1 UART transmitter for the 5-digit kHz string plus " kHz\r\n" suffix (11 bytes per frame).
// Define LEADING_ZERO_BLANK_EN to replace leading '0' digits (except the 1 kHz place) with spaces.
module freq_ascii_uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [39:0] ASCII,
  input  logic        SEND,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_CHAR = 4'd10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    char_idx;
  logic [39:0]   shadow;
  logic [39:0]   latch_val;
  logic [7:0]    cur_char;
  logic [2:0]    next_bit_idx;
  logic          bit_end;

  assign bit_end      = (baud_cnt == LAST_CNT);
  assign next_bit_idx = bit_idx + 3'd1;

`ifdef LEADING_ZERO_BLANK_EN
  logic blank0, blank1, blank2, blank3;

  // Blanking cascades: a digit is blanked only if every more-significant digit was '0' too.
  always_comb begin
    blank0    = (ASCII[39:32] == 8'h30);
    blank1    = blank0 && (ASCII[31:24] == 8'h30);
    blank2    = blank1 && (ASCII[23:16] == 8'h30);
    blank3    = blank2 && (ASCII[15:8]  == 8'h30);
    latch_val = ASCII;
    if (blank0) latch_val[39:32] = 8'h20;
    if (blank1) latch_val[31:24] = 8'h20;
    if (blank2) latch_val[23:16] = 8'h20;
    if (blank3) latch_val[15:8]  = 8'h20;
  end
`else
  always_comb begin
    latch_val = ASCII;
  end
`endif

  always_comb begin
    cur_char = '0;
    case (char_idx)
      4'd0:    cur_char = shadow[39:32];
      4'd1:    cur_char = shadow[31:24];
      4'd2:    cur_char = shadow[23:16];
      4'd3:    cur_char = shadow[15:8];
      4'd4:    cur_char = shadow[7:0];
      4'd5:    cur_char = 8'h20;
      4'd6:    cur_char = 8'h6B;
      4'd7:    cur_char = 8'h48;
      4'd8:    cur_char = 8'h7A;
      4'd9:    cur_char = 8'h0D;
      4'd10:   cur_char = 8'h0A;
      default: cur_char = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      TX       <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      shadow   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (SEND) begin
            shadow   <= latch_val;
            char_idx <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            TX       <= 1'b0;
            BUSY     <= 1'b1;
            state    <= START;
          end else begin
            TX <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            TX       <= cur_char[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              TX    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit_idx;
              TX      <= cur_char[next_bit_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (char_idx != LAST_CHAR) begin
              // Next start bit follows the stop bit directly: no inter-character gap.
              char_idx <= char_idx + 4'd1;
              TX       <= 1'b0;
              state    <= START;
            end else begin
              char_idx <= '0;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_ascii_uart_tx.sv
// Self-checking bench for freq_ascii_uart_tx at 16 clocks per bit, against a frame-level reference model.
module tb_freq_ascii_uart_tx;

  localparam int CPB   = 16;
  localparam int CHARW = 10 * CPB;
  localparam int FRAME = 11 * CHARW;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] ascii;
  logic        send;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic tx_log   [4000];
  logic busy_log [4000];
  logic done_log [4000];

  freq_ascii_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .CLK  (clk),
    .RST  (rst),
    .ASCII(ascii),
    .SEND (send),
    .TX   (tx),
    .BUSY (busy),
    .DONE (done)
  );

  always #5 clk = ~clk;

  // Reference: the byte the host should receive at position idx of a frame latched from a.
  function automatic logic [7:0] model_char(input logic [39:0] a, input int idx);
    logic [7:0] d [5];
    logic       lead;
    for (int k = 0; k < 5; k++) d[k] = 8'(a >> (8 * (4 - k)));
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (lead && d[k] == 8'h30) d[k] = 8'h20;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    case (idx)
      0, 1, 2, 3, 4: return d[idx];
      5:  return 8'h20;
      6:  return 8'h6B;
      7:  return 8'h48;
      8:  return 8'h7A;
      9:  return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Ideal TX level t cycles after the accept edge.
  function automatic logic exp_tx(input logic [39:0] a, input int t);
    int c = t / CHARW;
    int p = (t % CHARW) / CPB;
    logic [7:0] ch;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    ch = model_char(a, c);
    return ch[p-1];
  endfunction

  function automatic int tx_errors(input int base, input logic [39:0] a);
    int n = 0;
    for (int t = 0; t < FRAME; t++)
      if (tx_log[base+t] !== exp_tx(a, t)) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(input int base, input int c);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = tx_log[base + c*CHARW + (1+b)*CPB + CPB/2];
    return v;
  endfunction

  function automatic int done_count(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int idle_errors(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) n++;
    return n;
  endfunction

  function automatic logic [39:0] rand_ascii();
    logic [39:0] a;
    for (int k = 0; k < 5; k++)
      a = {a[31:0], ($urandom_range(0, 1) == 1) ? 8'h30 : 8'($urandom_range(0, 255))};
    return a;
  endfunction

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = tx;
      busy_log[i] = busy;
      done_log[i] = done;
    end
  endtask

  // Presents SEND for exactly one accept edge (or leaves it high), returning 2 time units after it.
  task automatic accept(input logic [39:0] a, input logic hold);
    ascii = a;
    send  = 1'b1;
    @(posedge clk);
    #2;
    if (!hold) send = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0; ascii = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_state: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, done);
    end
    #1 rst = 1'b0;
    record(100);
    tests++;
    if (idle_errors(0, 100) != 0 || done_count(0, 100) != 0) begin
      fails++; $display("FAIL reset_hold: %0d bad idle cycles, %0d DONE pulses, want 0 0",
                        idle_errors(0, 100), done_count(0, 100));
    end
  endtask

  task automatic test_frame();
    logic [7:0] want [11];
    int bad;
    want = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h20, 8'h6B, 8'h48, 8'h7A, 8'h0D, 8'h0A};
    accept(40'h3132333435, 1'b0);
    record(1800);
    tests++;
    if (tx_log[0] !== 1'b0) begin
      fails++; $display("FAIL frame_start_edge: tx=%b, want 0", tx_log[0]);
    end
    bad = 0;
    for (int c = 0; c < 11; c++) if (decode(0, c) !== want[c]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL frame_bytes: %0d wrong bytes, first byte %h want %h", bad, decode(0, 0), want[0]);
    end
    tests++;
    if (tx_errors(0, 40'h3132333435) != 0) begin
      fails++; $display("FAIL frame_waveform: %0d wrong cycles, want 0", tx_errors(0, 40'h3132333435));
    end
    tests++;
    if (done_count(0, 1800) != 1 || done_log[FRAME] !== 1'b1) begin
      fails++; $display("FAIL frame_done: pulses=%0d at1760=%b, want 1 1", done_count(0, 1800), done_log[FRAME]);
    end
    tests++;
    if (busy_log[FRAME-1] !== 1'b1 || busy_log[FRAME] !== 1'b0) begin
      fails++; $display("FAIL frame_busy_fall: busy[1759]=%b busy[1760]=%b, want 1 0",
                        busy_log[FRAME-1], busy_log[FRAME]);
    end
  endtask

  task automatic test_ignore_send();
    logic [39:0] a = rand_ascii();
    accept(a, 1'b0);
    fork
      record(2200);
      begin
        repeat (500) @(posedge clk);
        #2 ascii = 40'h3939393939; send = 1'b1;
        @(posedge clk);
        #2 send = 1'b0;
      end
    join
    tests++;
    if (tx_errors(0, a) != 0) begin
      fails++; $display("FAIL ignore_send_bytes: %0d wrong cycles for ascii %h, want 0", tx_errors(0, a), a);
    end
    tests++;
    if (done_count(0, 2200) != 1 || done_log[FRAME] !== 1'b1 || idle_errors(FRAME + 1, 2200) != 0) begin
      fails++; $display("FAIL ignore_send_single: pulses=%0d idle_errs=%0d, want 1 0",
                        done_count(0, 2200), idle_errors(FRAME + 1, 2200));
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] a = rand_ascii();
    logic [39:0] b = rand_ascii();
    accept(a, 1'b0);
    repeat (799) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_mid_state: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, done);
    end
    #1 rst = 1'b0;
    record(10);
    tests++;
    if (idle_errors(0, 10) != 0 || done_count(0, 10) != 0) begin
      fails++; $display("FAIL reset_mid_idle: %0d bad cycles, want 0", idle_errors(0, 10));
    end
    accept(b, 1'b0);
    record(1800);
    tests++;
    if (tx_errors(0, b) != 0) begin
      fails++; $display("FAIL reset_mid_refresh: %0d wrong cycles, want 0", tx_errors(0, b));
    end
    tests++;
    if (done_count(0, 1800) != 1 || done_log[FRAME] !== 1'b1) begin
      fails++; $display("FAIL reset_mid_done: pulses=%0d at1760=%b, want 1 1", done_count(0, 1800), done_log[FRAME]);
    end
  endtask

  task automatic test_blanking();
    logic [7:0] want_a [5];
    logic [7:0] want_b [5];
    logic [39:0] a;
    int bad;
`ifdef LEADING_ZERO_BLANK_EN
    want_a = '{8'h20, 8'h20, 8'h31, 8'h30, 8'h30};
    want_b = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
`else
    want_a = '{8'h30, 8'h30, 8'h31, 8'h30, 8'h30};
    want_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
`endif
    accept(40'h3030313030, 1'b0);
    record(1800);
    bad = 0;
    for (int c = 0; c < 5; c++) if (decode(0, c) !== want_a[c]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL blank_3030313030: %0d wrong digits, first %h want %h", bad, decode(0, 0), want_a[0]);
    end
    accept(40'h3030303030, 1'b0);
    record(1800);
    bad = 0;
    for (int c = 0; c < 5; c++) if (decode(0, c) !== want_b[c]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL blank_all_zero: %0d wrong digits, last %h want %h", bad, decode(0, 4), want_b[4]);
    end
    for (int r = 0; r < 4; r++) begin
      a = rand_ascii();
      accept(a, 1'b0);
      record(1800);
      tests++;
      if (tx_errors(0, a) != 0 || done_count(0, 1800) != 1) begin
        fails++; $display("FAIL random_frame_%0d: ascii %h gives %0d wrong cycles, %0d DONE, want 0 1",
                          r, a, tx_errors(0, a), done_count(0, 1800));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] a = rand_ascii();
    accept(a, 1'b1);
    fork
      record(3600);
      begin
        repeat (1800) @(posedge clk);
        #2 send = 1'b0;
      end
    join
    tests++;
    if (done_count(0, 3600) != 2 || done_log[FRAME] !== 1'b1 || done_log[2*FRAME+1] !== 1'b1) begin
      fails++; $display("FAIL b2b_done: pulses=%0d at1760=%b at3521=%b, want 2 1 1",
                        done_count(0, 3600), done_log[FRAME], done_log[2*FRAME+1]);
    end
    tests++;
    if (tx_log[FRAME] !== 1'b1 || tx_log[FRAME+1] !== 1'b0) begin
      fails++; $display("FAIL b2b_gap: tx[1760]=%b tx[1761]=%b, want 1 0", tx_log[FRAME], tx_log[FRAME+1]);
    end
    tests++;
    if (tx_errors(0, a) != 0 || tx_errors(FRAME + 1, a) != 0) begin
      fails++; $display("FAIL b2b_frames: %0d and %0d wrong cycles, want 0 0",
                        tx_errors(0, a), tx_errors(FRAME + 1, a));
    end
    tests++;
    if (idle_errors(2*FRAME + 2, 3600) != 0) begin
      fails++; $display("FAIL b2b_release: %0d bad idle cycles after release, want 0", idle_errors(2*FRAME + 2, 3600));
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_send();
    test_reset_mid();
    test_blanking();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
